// File: rtl/shifter_pkg.sv
// Shared constants and types for the pipelined barrel shifter.
package shifter_pkg;

    localparam int SHIFT_MODE_W = 3;

    localparam logic [SHIFT_MODE_W-1:0] SHIFT_SLL = 3'd0;
    localparam logic [SHIFT_MODE_W-1:0] SHIFT_SRL = 3'd1;
    localparam logic [SHIFT_MODE_W-1:0] SHIFT_SRA = 3'd2;
    localparam logic [SHIFT_MODE_W-1:0] SHIFT_ROL = 3'd3;
    localparam logic [SHIFT_MODE_W-1:0] SHIFT_ROR = 3'd4;

    typedef logic [SHIFT_MODE_W-1:0] shift_mode_t;

endpackage

// File: rtl/shift_level.sv
// One combinational level of the shift network: shifts or rotates by a fixed
// AMOUNT when enabled. Modes outside the defined set pass the data through.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AMOUNT = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] data_out
);

    // Select the fixed-distance shift/rotate for the current mode.
    always_comb begin
        data_out = data_in;
        if (en) begin
            case (mode)
                SHIFT_SLL: data_out = {data_in[WIDTH-AMOUNT-1:0], {AMOUNT{1'b0}}};
                SHIFT_SRL: data_out = {{AMOUNT{1'b0}}, data_in[WIDTH-1:AMOUNT]};
                SHIFT_SRA: data_out = {{AMOUNT{data_in[WIDTH-1]}}, data_in[WIDTH-1:AMOUNT]};
                SHIFT_ROL: data_out = {data_in[WIDTH-AMOUNT-1:0], data_in[WIDTH-1:WIDTH-AMOUNT]};
                SHIFT_ROR: data_out = {data_in[AMOUNT-1:0], data_in[WIDTH-1:AMOUNT]};
                default:   data_out = data_in;
            endcase
        end else begin
            data_out = data_in;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter with valid/ready on both ports.
// The log2(WIDTH) shift levels are split into PIPE_STAGES groups, each group
// followed by a register slice; mode, shift amount and valid travel along.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shift,
    input  logic [SHIFT_MODE_W-1:0]  in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);

    localparam int LEVELS     = $clog2(WIDTH);
    localparam int GRP_LEVELS = (LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;

    // Stage registers
    logic [PIPE_STAGES-1:0] stg_valid_r;
    logic [WIDTH-1:0]       stg_data_r  [PIPE_STAGES];
    shift_mode_t            stg_mode_r  [PIPE_STAGES];
    logic [LEVELS-1:0]      stg_shift_r [PIPE_STAGES];

    // Per-stage inputs (previous slice, or the input port for stage 0)
    logic [PIPE_STAGES-1:0] src_valid_s;
    logic [WIDTH-1:0]       src_data_s  [PIPE_STAGES];
    shift_mode_t            src_mode_s  [PIPE_STAGES];
    logic [LEVELS-1:0]      src_shift_s [PIPE_STAGES];

    logic [WIDTH-1:0]       res_s [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] ld_s;
    logic                   unused_bits_s;

    // Route each stage's source: input port for stage 0, previous slice otherwise.
    always_comb begin
        src_valid_s[0] = in_valid;
        src_data_s[0]  = in_data;
        src_mode_s[0]  = in_mode;
        src_shift_s[0] = in_shift;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            src_valid_s[s] = stg_valid_r[s-1];
            src_data_s[s]  = stg_data_r[s-1];
            src_mode_s[s]  = stg_mode_r[s-1];
            src_shift_s[s] = stg_shift_r[s-1];
        end
    end

    // Ready chain: a stage loads when it is empty or its successor takes its content.
    always_comb begin
        ld_s = {PIPE_STAGES{1'b0}};
        ld_s[PIPE_STAGES-1] = !stg_valid_r[PIPE_STAGES-1] || out_ready;
        for (int s = PIPE_STAGES - 2; s >= 0; s--) begin
            ld_s[s] = !stg_valid_r[s] || ld_s[s+1];
        end
    end

    // Shift network; the first level of every group starts from that group's source.
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int GRP = k / GRP_LEVELS;
        logic [WIDTH-1:0] lvl_in_s;
        logic [WIDTH-1:0] lvl_out_s;

        if ((k % GRP_LEVELS) == 0) begin : g_first
            assign lvl_in_s = src_data_s[GRP];
        end else begin : g_chain
            assign lvl_in_s = g_lvl[k-1].lvl_out_s;
        end

        shift_level #(
            .WIDTH  (WIDTH),
            .AMOUNT (2 ** k)
        ) u_level (
            .data_in  (lvl_in_s),
            .en       (src_shift_s[GRP][k]),
            .mode     (src_mode_s[GRP]),
            .data_out (lvl_out_s)
        );
    end

    // Stage result: last level of the group, or pass-through for a group with no levels.
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LO = s * GRP_LEVELS;
        localparam int HI = ((s + 1) * GRP_LEVELS < LEVELS) ? (s + 1) * GRP_LEVELS : LEVELS;
        if (HI > LO) begin : g_net
            assign res_s[s] = g_lvl[HI-1].lvl_out_s;
        end else begin : g_pass
            assign res_s[s] = src_data_s[s];
        end
    end

    // Register slices: clear on reset, otherwise load whenever the ready chain allows.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                stg_valid_r[s] <= 1'b0;
                stg_data_r[s]  <= {WIDTH{1'b0}};
                stg_mode_r[s]  <= {SHIFT_MODE_W{1'b0}};
                stg_shift_r[s] <= {LEVELS{1'b0}};
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (ld_s[s]) begin
                    stg_valid_r[s] <= src_valid_s[s];
                    stg_data_r[s]  <= res_s[s];
                    stg_mode_r[s]  <= src_mode_s[s];
                    stg_shift_r[s] <= src_shift_s[s];
                end
            end
        end
    end

    // Collect control bits that later stages no longer need (consumed shift bits, tail mode).
    always_comb begin
        unused_bits_s = 1'b0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            unused_bits_s = unused_bits_s ^ (^stg_shift_r[s]) ^ (^stg_mode_r[s])
                          ^ (^src_shift_s[s]) ^ (^src_mode_s[s]);
        end
    end

    assign in_ready  = ld_s[0];
    assign out_valid = stg_valid_r[PIPE_STAGES-1];
    assign out_data  = stg_data_r[PIPE_STAGES-1];

endmodule
